key_debounce: RTL

//  Front-end conditioner for the air-conditioner panel's active-low push-buttons.

---
 rtl/key_pkg.sv | 11 +
 rtl/key_debounce_if.sv | 10 +
 rtl/debounce_cell.sv | 111 +++++++++++
 rtl/key_debounce.sv | 36 +++
 4 files changed

// File: rtl/key_pkg.sv
// key_pkg: shared FSM state type, default timing and counter sizing for key_debounce
package key_pkg;
  typedef enum logic [2:0] {RELEASED, PRESS_WAIT, PRESSED, HELD, RELEASE_WAIT} key_state_e;
  localparam int DEF_NUM_KEYS      = 4;
  localparam int DEF_DB_CYCLES     = 1_000_000;
  localparam int DEF_HOLD_CYCLES   = 50_000_000;
  localparam int DEF_REPEAT_CYCLES = 12_500_000;
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/key_debounce_if.sv
// key_debounce_if: raw key pins in, conditioned per-key level and strobes out
interface key_debounce_if #(parameter int NUM_KEYS = 4);
  logic [NUM_KEYS-1:0] key_n;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_repeat;
  modport master (output key_n, input key_level, key_press, key_release, key_repeat);
  modport slave (input key_n, output key_level, key_press, key_release, key_repeat);
endinterface

// File: rtl/debounce_cell.sv
// debounce_cell: synchroniser, debounce/auto-repeat FSM and counters for one key
module debounce_cell
  import key_pkg::*;
#(
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);
  localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ?
                        ((HOLD_CYCLES > DB_CYCLES) ? HOLD_CYCLES : DB_CYCLES) :
                        ((REPEAT_CYCLES > DB_CYCLES) ? REPEAT_CYCLES : DB_CYCLES);
  localparam int CW = cnt_width(MAXC);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t DB_LAST   = cnt_t'(DB_CYCLES - 1);
  localparam cnt_t HOLD_LAST = cnt_t'(HOLD_CYCLES - 1);
  localparam cnt_t REP_LAST  = cnt_t'(REPEAT_CYCLES - 1);
  localparam cnt_t ONE       = cnt_t'(1);
  key_state_e state_q, state_d;
  logic [1:0] sync_q, sync_d;
  cnt_t cnt_q, cnt_d, hold_q, hold_d, rep_q, rep_d;
  logic level_q, level_d, press_q, press_d, rel_q, rel_d, rpt_q, rpt_d;
  logic p;
  assign p = ~sync_q[1];
  always_comb begin
    sync_d  = {sync_q[0], key_n};
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    rep_d   = rep_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    rpt_d   = 1'b0;
    case (state_q)
      RELEASED: if (p) begin
        state_d = PRESS_WAIT;
        cnt_d   = '0;
      end
      PRESS_WAIT: if (!p) state_d = RELEASED;
      else if (cnt_q == DB_LAST) begin
        state_d = PRESSED;
        level_d = 1'b1;
        press_d = 1'b1;
        hold_d  = '0;
      end else cnt_d = cnt_q + ONE;
      PRESSED: if (!p) begin
        state_d = RELEASE_WAIT;
        cnt_d   = '0;
      end else if (hold_q == HOLD_LAST) begin
        // hold count saturates here when auto-repeat is disabled
        if (REPEAT_EN) begin
          state_d = HELD;
          rpt_d   = 1'b1;
          rep_d   = '0;
        end
      end else hold_d = hold_q + ONE;
      HELD: if (!p) begin
        state_d = RELEASE_WAIT;
        cnt_d   = '0;
      end else if (rep_q == REP_LAST) begin
        rpt_d = 1'b1;
        rep_d = '0;
      end else rep_d = rep_q + ONE;
      RELEASE_WAIT: if (p) begin
        state_d = PRESSED;
        hold_d  = '0;
      end else if (cnt_q == DB_LAST) begin
        state_d = RELEASED;
        level_d = 1'b0;
        rel_d   = 1'b1;
      end else cnt_d = cnt_q + ONE;
      default: state_d = RELEASED;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state_q <= RELEASED;
      cnt_q   <= '0;
      hold_q  <= '0;
      rep_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      rep_q   <= rep_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      rpt_q   <= rpt_d;
    end
  end
  assign level = level_q;
  assign press = press_q;
  assign rel   = rel_q;
  assign rpt   = rpt_q;
endmodule

// File: rtl/key_debounce.sv
// key_debounce: NUM_KEYS independent debounce cells for active-low panel buttons
module key_debounce
  import key_pkg::*;
#(
  parameter int NUM_KEYS      = DEF_NUM_KEYS,
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter bit REPEAT_EN     = 1'b1
) (
  input logic clk,
  input logic rst_n,
  key_debounce_if.slave bus
);
  logic [NUM_KEYS-1:0] lvl, prs, rls, rpt;
  for (genvar i = 0; i < NUM_KEYS; i++) begin : gen_cell
    debounce_cell #(
      .DB_CYCLES(DB_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .REPEAT_EN(REPEAT_EN)
    ) u_cell (
      .clk(clk),
      .rst_n(rst_n),
      .key_n(bus.key_n[i]),
      .level(lvl[i]),
      .press(prs[i]),
      .rel(rls[i]),
      .rpt(rpt[i])
    );
  end
  assign bus.key_level   = lvl;
  assign bus.key_press   = prs;
  assign bus.key_release = rls;
  assign bus.key_repeat  = rpt;
endmodule
